pe_mac_array: RTL and testbench

Parametrised multi-lane multiply-accumulate processing element for the convolution datapath. It is the next generation of the current processing element, with these changes:
- single clock domain;
- streaming valid/ready input with stall support;
- per-lane bias or feedback (output reuse) seeding;
- weight-address generation;
- held result with output backpressure.

It sits between the activation/weight fetch stage and the activation/pooling stage.

---
 rtl/pe_pkg.sv | 27 ++
 rtl/pe_mac_lane.sv | 81 ++++++++
 rtl/pe_mac_array.sv | 122 ++++++++++++
 tb/tb_pe_mac_array.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types, widths and helpers for the multi-lane MAC processing element.
// Saturating accumulation is built when PE_SATURATE_EN is defined.
package pe_pkg;

  localparam int LANES_DEF  = 8;
  localparam int DW_DEF     = 8;
  localparam int ACCW_DEF   = 20;
  localparam int OPS_W_DEF  = 10;
  localparam int ADDR_W_DEF = 11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_OUT
  } pe_state_e;

  // Signed add overflow from the operand and result sign bits.
  function automatic logic add_ovf(
    input logic a_s,
    input logic b_s,
    input logic r_s
  );
    return (a_s == b_s) && (r_s != a_s);
  endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// One MAC lane: product register, seeded accumulator, optional saturation.
// PE_SATURATE_EN selects clamping with a sticky overflow flag.
module pe_mac_lane
  import pe_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   seed_en_i,
  input  logic                   fb_sel_i,
  input  logic signed [ACCW-1:0] bias_i,
  input  logic                   accept_i,
  input  logic signed [DW-1:0]   act_i,
  input  logic signed [DW-1:0]   wgt_i,
  output logic signed [ACCW-1:0] acc_o,
  output logic                   ovf_o
);

  logic signed [2*DW-1:0] prod_q, prod_d;
  logic                   pv_q;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] addend, sum;

  assign prod_d = (2*DW)'(act_i) * (2*DW)'(wgt_i);
  assign addend = ACCW'(prod_q);
  assign sum    = acc_q + addend;
  assign acc_o  = acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q <= '0;
      pv_q   <= 1'b0;
      acc_q  <= '0;
    end else begin
      if (accept_i) prod_q <= prod_d;
      pv_q  <= accept_i;
      acc_q <= acc_d;
    end
  end

`ifdef PE_SATURATE_EN
  logic ovf_q, ovf_d, of;

  assign of    = add_ovf(acc_q[ACCW-1], addend[ACCW-1], sum[ACCW-1]);
  assign ovf_o = ovf_q;

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (seed_en_i) begin
      acc_d = fb_sel_i ? acc_q : bias_i;
      ovf_d = 1'b0;
    end else if (pv_q) begin
      if (of) begin
        // Both operands share a sign on overflow; clamp toward it.
        acc_d = acc_q[ACCW-1] ? {1'b1, {(ACCW-1){1'b0}}}
                              : {1'b0, {(ACCW-1){1'b1}}};
        ovf_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end
`else
  assign ovf_o = 1'b0;

  always_comb begin
    acc_d = acc_q;
    if (seed_en_i)  acc_d = fb_sel_i ? acc_q : bias_i;
    else if (pv_q)  acc_d = sum;
  end
`endif

endmodule

// File: rtl/pe_mac_array.sv
// Multi-lane MAC processing element: control FSM, beat counter, weight address.
// Lane arithmetic saturates when PE_SATURATE_EN is defined.
module pe_mac_array
  import pe_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DW     = DW_DEF,
  parameter int ACCW   = ACCW_DEF,
  parameter int OPS_W  = OPS_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic [OPS_W-1:0]      cfg_n_ops,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic [LANES*ACCW-1:0] cfg_bias,
  input  logic [LANES-1:0]      cfg_fb_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic [LANES*DW-1:0]   in_weight,
  output logic [ADDR_W-1:0]     w_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*ACCW-1:0] out_data,
  output logic [LANES-1:0]      ovf,
  output logic                  busy,
  output logic                  layer_done
);

  pe_state_e         state_q;
  logic [OPS_W-1:0]  n_ops_q, cnt_q, cnt_inc;
  logic [ADDR_W-1:0] base_q, w_addr_q;
  logic              in_ready_q, out_valid_q, busy_q, done_q;
  logic              accept, seed_en;

  assign cnt_inc    = cnt_q + 1'b1;
  assign accept     = in_valid & in_ready_q;
  assign seed_en    = (state_q == S_IDLE) & cfg_load;
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign layer_done = done_q;
  assign w_addr     = w_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      n_ops_q     <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      w_addr_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cfg_load) begin
            n_ops_q  <= cfg_n_ops;
            base_q   <= cfg_base_addr;
            cnt_q    <= '0;
            w_addr_q <= cfg_base_addr;
            busy_q   <= 1'b1;
            if (cfg_n_ops == '0) begin
              state_q     <= S_OUT;
              out_valid_q <= 1'b1;
            end else begin
              state_q    <= S_RUN;
              in_ready_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (in_valid) begin
            cnt_q    <= cnt_inc;
            w_addr_q <= w_addr_q + 1'b1;
            if (cnt_inc == n_ops_q) begin
              state_q    <= S_FLUSH;
              in_ready_q <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          state_q     <= S_OUT;
          out_valid_q <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            w_addr_q    <= base_q;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_mac_lane #(
      .DW  (DW),
      .ACCW(ACCW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .seed_en_i(seed_en),
      .fb_sel_i (cfg_fb_sel[i]),
      .bias_i   (cfg_bias[i*ACCW +: ACCW]),
      .accept_i (accept),
      .act_i    (in_data[i*DW +: DW]),
      .wgt_i    (in_weight[i*DW +: DW]),
      .acc_o    (out_data[i*ACCW +: ACCW]),
      .ovf_o    (ovf[i])
    );
  end

endmodule

// File: tb/tb_pe_mac_array.sv
// Scoreboard bench for pe_mac_array: directed layers, stalls, feedback,
// overflow, zero-op layers, backpressure and asynchronous reset.
module tb_pe_mac_array;

  localparam int LANES  = 8;
  localparam int DW     = 8;
  localparam int ACCW   = 20;
  localparam int OPS_W  = 10;
  localparam int ADDR_W = 11;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_load;
  logic [OPS_W-1:0]      cfg_n_ops;
  logic [ADDR_W-1:0]     cfg_base_addr;
  logic [LANES*ACCW-1:0] cfg_bias;
  logic [LANES-1:0]      cfg_fb_sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_data;
  logic [LANES*DW-1:0]   in_weight;
  logic [ADDR_W-1:0]     w_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES*ACCW-1:0] out_data;
  logic [LANES-1:0]      ovf;
  logic                  busy;
  logic                  layer_done;

  always #5 clk = ~clk;

  pe_mac_array #(
    .LANES (LANES),
    .DW    (DW),
    .ACCW  (ACCW),
    .OPS_W (OPS_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_load     (cfg_load),
    .cfg_n_ops    (cfg_n_ops),
    .cfg_base_addr(cfg_base_addr),
    .cfg_bias     (cfg_bias),
    .cfg_fb_sel   (cfg_fb_sel),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_weight    (in_weight),
    .w_addr       (w_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .ovf          (ovf),
    .busy         (busy),
    .layer_done   (layer_done)
  );

  typedef struct {
    logic [LANES*ACCW-1:0] d;
    logic [LANES-1:0]      o;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   bias[LANES];
  int   dat[LANES];
  int   wgt[LANES];
  int   ex[LANES];

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic push_exp(input logic [LANES-1:0] o);
    exp_t e;
    for (int i = 0; i < LANES; i++) e.d[i*ACCW +: ACCW] = ACCW'(ex[i]);
    e.o = o;
    sb.push_back(e);
  endtask

  // Monitor: every output handshake retires one scoreboard entry.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin : mon
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=1 required=0");
      end else begin
        e = sb.pop_front();
        for (int i = 0; i < LANES; i++)
          chk($sformatf("lane%0d", i),
              64'($signed(out_data[i*ACCW +: ACCW])),
              64'($signed(e.d[i*ACCW +: ACCW])));
        chk("ovf", 64'(ovf), 64'(e.o));
      end
    end
  end

  task automatic load(input int n, input int base, input logic [LANES-1:0] fb);
    @(posedge clk); #1;
    cfg_load      = 1'b1;
    cfg_n_ops     = OPS_W'(n);
    cfg_base_addr = ADDR_W'(base);
    cfg_fb_sel    = fb;
    for (int i = 0; i < LANES; i++) cfg_bias[i*ACCW +: ACCW] = ACCW'(bias[i]);
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic beat(input int addr);
    int k = 0;
    in_valid = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      in_data[i*DW +: DW]   = DW'(dat[i]);
      in_weight[i*DW +: DW] = DW'(wgt[i]);
    end
    @(negedge clk);
    while (!in_ready && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("beat_ready_timeout", 64'(in_ready), 64'(1));
    chk("w_addr_beat", 64'(w_addr), 64'(addr));
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_data   = {LANES{8'h63}};
    in_weight = {LANES{8'h55}};
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("out_valid_timeout", 64'(out_valid), 64'(1));
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic set_all(input int b, input int d, input int w);
    for (int i = 0; i < LANES; i++) begin
      bias[i] = b;
      dat[i]  = d;
      wgt[i]  = w;
    end
  endtask

  initial begin
    rst           = 1'b0;
    cfg_load      = 1'b0;
    cfg_n_ops     = '0;
    cfg_base_addr = '0;
    cfg_bias      = '0;
    cfg_fb_sel    = '0;
    in_valid      = 1'b0;
    in_data       = '0;
    in_weight     = '0;
    out_ready     = 1'b1;

    // Reset values
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(layer_done), 64'(0));
    chk("rst_w_addr", 64'(w_addr), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 64'(busy), 64'(0));

    // No-stall layer: 4 beats of 3*2 onto bias 10+i
    set_all(0, 3, 2);
    for (int i = 0; i < LANES; i++) begin
      bias[i] = 10 + i;
      ex[i]   = 34 + i;
    end
    push_exp('0);
    load(4, 'h100, '0);
    #3;
    chk("load_busy", 64'(busy), 64'(1));
    chk("load_in_ready", 64'(in_ready), 64'(1));
    for (int b = 0; b < 4; b++) beat('h100 + b);
    #3;
    chk("flush_in_ready", 64'(in_ready), 64'(0));
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk("out_after_flush", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    chk("done_pulse", 64'(layer_done), 64'(1));
    chk("done_busy", 64'(busy), 64'(0));
    chk("idle_w_addr", 64'(w_addr), 64'('h100));
    @(posedge clk); #1;
    chk("done_single", 64'(layer_done), 64'(0));

    // Same layer with a 5-cycle stall after beat 2
    push_exp('0);
    load(4, 'h100, '0);
    beat('h100);
    beat('h101);
    for (int s = 0; s < 5; s++) begin
      #3;
      chk("stall_w_addr", 64'(w_addr), 64'('h102));
      @(posedge clk); #1;
    end
    beat('h102);
    beat('h103);
    wait_valid();
    wait_idle();

    // Feedback on lane 0, new bias elsewhere
    set_all(100, 1, 1);
    for (int i = 0; i < LANES; i++) ex[i] = 101;
    ex[0] = 35;
    push_exp('0);
    load(1, 'h020, 8'h01);
    beat('h020);
    wait_valid();
    wait_idle();

    // Overflow at both ends of the accumulator range
    set_all(0, 127, 127);
    bias[0] = 524287;
    bias[1] = -524288;
    wgt[1]  = -128;
    for (int i = 0; i < LANES; i++) ex[i] = 16129;
`ifdef PE_SATURATE_EN
    ex[0] = 524287;
    ex[1] = -524288;
    push_exp(8'h03);
`else
    ex[0] = -508160;
    ex[1] = 508032;
    push_exp('0);
`endif
    load(1, 'h000, '0);
    beat('h000);
    wait_valid();
    wait_idle();

    // Zero-op layer: result is the seeds, ovf cleared
    set_all(0, 0, 0);
    for (int i = 0; i < LANES; i++) begin
      bias[i] = i - 3;
      ex[i]   = i - 3;
    end
    push_exp('0);
    load(0, 'h040, '0);
    chk("zero_in_ready", 64'(in_ready), 64'(0));
    wait_valid();
    wait_idle();

    // Backpressure with address wrap; cfg_load ignored while held
    out_ready = 1'b0;
    set_all(0, 0, -2);
    for (int i = 0; i < LANES; i++) begin
      dat[i] = i + 1;
      ex[i]  = -4 * (i + 1);
    end
    push_exp('0);
    load(2, 'h7FF, '0);
    beat('h7FF);
    beat('h000);
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      cfg_load      = (k == 3);
      cfg_n_ops     = OPS_W'(5);
      cfg_base_addr = ADDR_W'(3);
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_lane0", 64'($signed(out_data[0 +: ACCW])), 64'(-4));
      chk("hold_lane7", 64'($signed(out_data[7*ACCW +: ACCW])), 64'(-32));
    end
    cfg_load = 1'b0;
    chk("hold_w_addr", 64'(w_addr), 64'('h001));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_busy", 64'(busy), 64'(0));
    chk("bp_w_addr", 64'(w_addr), 64'('h7FF));

    // Asynchronous reset in the middle of a layer
    set_all(5, 3, 3);
    load(3, 'h010, '0);
    beat('h010);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_out_valid", 64'(out_valid), 64'(0));
    chk("arst_out_data", 64'(out_data), 64'(0));
    chk("arst_w_addr", 64'(w_addr), 64'(0));
    chk("arst_ovf", 64'(ovf), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 64'(busy), 64'(0));

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
